fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: IMEM_AW, default 12, instruction-memory word-address width.
REQ-002 Parameter: NOP_WORD, default 32'h00000000, instruction word inserted as a bubble.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard hold; freezes PC and F/D register.
REQ-006 flush  input  1  replace the F/D contents with a bubble on the next edge.
REQ-007 branch_taken  input  1  redirect request from execute.
REQ-008 branch_target  input  32  word address for the redirect.
REQ-009 imem_addr  output  IMEM_AW  equals pc[IMEM_AW-1:0], driven combinationally from the PC register.
REQ-010 imem_q  input  32  instruction word for imem_addr, valid in the same cycle (asynchronous read).
REQ-011 fd_instr  output  32  latched instruction for decode.
REQ-012 fd_opcode  output  5  equals fd_instr[31:27]; feeds the opcode decoder.
REQ-013 fd_pc  output  32  word address of fd_instr.
REQ-014 fd_pc_plus1  output  32  fd_pc + 1, modulo 2^32.
REQ-015 fd_valid  output  1  1 = fd_instr is a real fetched instruction; 0 = bubble.
REQ-016 fetch_count  output  16  number of instructions accepted into F/D, saturating.

Function
REQ-017 PC is a 32-bit word address; sequential next PC is pc + 1, wrapping 32'hFFFFFFFF to 0.
REQ-018 State machine states: BOOT and RUN.
REQ-019 BOOT is entered on reset; it lasts exactly one cycle; the next edge always goes to RUN.
REQ-020 In BOOT: PC holds at 0, F/D loads a bubble, and stall, flush and branch_taken are ignored.
REQ-021 In RUN, update priority per edge is branch_taken, then flush, then stall, then normal.
REQ-022 branch_taken=1: pc <= branch_target; F/D loads a bubble (NOP_WORD, fd_valid=0, fd_pc=pc); this applies regardless of stall.
REQ-023 flush=1 with branch_taken=0: pc <= pc + 1 if stall=0, otherwise pc holds; F/D loads a bubble.
REQ-024 stall=1 with neither branch_taken nor flush: PC, F/D contents, fd_valid and fetch_count all hold.
REQ-025 Normal edge: fd_instr <= imem_q, fd_pc <= pc, fd_valid <= 1, pc <= pc + 1, fetch_count increments.
REQ-026 fetch_count increments only on edges where fd_valid is written to 1, and saturates at 16'hFFFF.
REQ-027 Bubble contents: fd_instr = NOP_WORD, fd_valid = 0, fd_pc = value of pc at that edge.
REQ-028 Fetch latency: an instruction at address A appears on fd_instr one edge after pc = A, with no stall.
REQ-029 Branch penalty: exactly one bubble cycle, then the instruction at branch_target is latched on the following edge.
REQ-030 fd_opcode and fd_pc_plus1 are pure combinational functions of the F/D register; they hold no separate state.

Reset
REQ-031 While reset_n=0, and immediately on its assertion regardless of clock, the block drives: pc=0, state=BOOT, fd_instr=NOP_WORD, fd_pc=0, fd_valid=0, fetch_count=0.
REQ-032 imem_addr=0 while reset_n=0.
REQ-033 Reset asserted mid-stall, mid-branch or mid-flush discards all pending requests; no partial update survives.
REQ-034 Deassertion of reset_n is synchronised by the integration; after it, the first edge executes BOOT and the second edge latches the instruction at address 0.

Verification
REQ-035 Reset release, imem[0..3]=I0..I3, no hazards -> edge1: fd_valid=0; edge2: fd_instr=I0, fd_pc=0; edge3: fd_instr=I1, fd_pc=1; fetch_count=2.
REQ-036 stall held 3 cycles after I1 is latched -> fd_instr=I1, pc=2, fetch_count unchanged for 3 edges; I2 is latched on the edge after stall drops.
REQ-037 branch_taken=1, branch_target=32'h40, with stall=1 in the same cycle -> next edge: fd_valid=0, pc=32'h40; following edge: fd_instr=imem[32'h40], fd_pc=32'h40, fd_pc_plus1=32'h41.
REQ-038 flush=1 with stall=1 and pc=5 -> next edge: bubble in F/D, pc stays 5; flush=1 with stall=0 -> bubble in F/D, pc=6.
REQ-039 Preload pc=32'hFFFFFFFF (via branch) -> fd_pc=32'hFFFFFFFF, fd_pc_plus1=0, next pc=0; preload fetch_count=16'hFFFE, then 3 fetches -> fetch_count=16'hFFFF.
REQ-040 Assert reset_n=0 between edges while stall=1 and fd_valid=1 -> outputs take their reset values immediately, before the next edge; fd_opcode=NOP_WORD[31:27].

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: hazard controls, instruction-memory port and F/D outputs.
interface fetch_stage_if #(
  parameter int IMEM_AW = 12
);
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_q;
  logic [31:0]        fd_instr;
  logic [4:0]         fd_opcode;
  logic [31:0]        fd_pc;
  logic [31:0]        fd_pc_plus1;
  logic               fd_valid;
  logic [15:0]        fetch_count;

  // Pipeline control and memory side: drives hazards and imem_q, observes F/D
  modport master (
    output stall, flush, branch_taken, branch_target, imem_q,
    input  imem_addr, fd_instr, fd_opcode, fd_pc, fd_pc_plus1, fd_valid, fetch_count
  );

  // Fetch stage itself
  modport slave (
    input  stall, flush, branch_taken, branch_target, imem_q,
    output imem_addr, fd_instr, fd_opcode, fd_pc, fd_pc_plus1, fd_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, F/D pipeline register with
// bubble insertion on branch/flush, hazard stall, and a saturating count of
// instructions accepted into F/D. One BOOT cycle follows every reset.
module fetch_stage #(
  parameter int          IMEM_AW  = 12,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_stage_if.slave bus
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fdpc_q, fdpc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [31:0] pc_inc_s;
  logic [15:0] count_inc_s;

  assign pc_inc_s    = pc_q + 32'd1;
  assign count_inc_s = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);

  // Next-state selection: branch beats flush beats stall beats a normal fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fdpc_d  = fdpc_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      ST_BOOT: begin
        // Hazard inputs are ignored; PC stays at 0 and F/D takes a bubble
        state_d = ST_RUN;
        pc_d    = 32'd0;
        instr_d = NOP_WORD;
        fdpc_d  = pc_q;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        if (bus.branch_taken) begin
          // Redirect wins even over a stall; the wrong-path word is dropped
          pc_d    = bus.branch_target;
          instr_d = NOP_WORD;
          fdpc_d  = pc_q;
          valid_d = 1'b0;
        end else if (bus.flush) begin
          pc_d    = bus.stall ? pc_q : pc_inc_s;
          instr_d = NOP_WORD;
          fdpc_d  = pc_q;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else begin
          pc_d    = pc_inc_s;
          instr_d = bus.imem_q;
          fdpc_d  = pc_q;
          valid_d = 1'b1;
          count_d = count_inc_s;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean boot
        state_d = ST_BOOT;
        pc_d    = 32'd0;
        instr_d = NOP_WORD;
        fdpc_d  = 32'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and F/D register update; reset clears everything immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= 32'd0;
      instr_q <= NOP_WORD;
      fdpc_q  <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fdpc_q  <= fdpc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Outputs are straight views of the registers; opcode and pc+1 derive from F/D
  assign bus.imem_addr   = pc_q[IMEM_AW-1:0];
  assign bus.fd_instr    = instr_q;
  assign bus.fd_opcode   = instr_q[31:27];
  assign bus.fd_pc       = fdpc_q;
  assign bus.fd_pc_plus1 = fdpc_q + 32'd1;
  assign bus.fd_valid    = valid_q;
  assign bus.fetch_count = count_q;

endmodule
